cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Completion stage directly downstream of the execute FUs (fu_alu and peers).
//   Captures each FU's finished result in a per-FU one-entry holding slot and
//   broadcasts up to CDB_W results per cycle on the common data bus (CDB) to
//   the RS/ROB. Round-robin arbitration across FUs; backpressures an FU whose
//   slot is still occupied and not granted this cycle.
// PARAMETERS
//   NUM_FU   4    number of FU result ports (power of 2, >= CDB_W)
//   CDB_W    2    CDB lanes per cycle (2-way superscalar)
//   TAG_W    5    ROB tag width
//   XLEN     32   data width
// PORTS
//   clock            in   1               system clock, posedge
//   reset            in   1               async, active-high
//   squash           in   1               mispredict flush, sync
//   fu_valid         in   NUM_FU          FU i presents a result this cycle
//   fu_tag           in   NUM_FU*TAG_W    ROB tag per FU
//   fu_value         in   NUM_FU*XLEN     result value per FU
//   fu_take_branch   in   NUM_FU          branch-taken flag per FU
//   fu_stall         out  NUM_FU          FU i must hold its output (not accepted)
//   cdb_valid        out  CDB_W           lane l carries a result
//   cdb_tag          out  CDB_W*TAG_W     lane tag
//   cdb_value        out  CDB_W*XLEN      lane value
//   cdb_take_branch  out  CDB_W           lane branch flag
//   cdb_fu_idx       out  CDB_W*log2(NUM_FU)  source FU of lane
// BEHAVIOUR
//   - Reset (async): all slots empty, rr_ptr=0; all cdb_* outputs 0,
//     fu_stall all 0. Reset mid-operation discards every held result.
//   - Slot i: {full, tag, value, take_branch}. cdb_* driven combinationally
//     from slot registers only (no input-to-CDB bypass); lanes with no grant
//     drive valid=0, tag/value/flags/idx=0.
//   - Grant: scan i = rr_ptr, rr_ptr+1, ... (mod NUM_FU); first CDB_W full slots
//     granted, packed lane0 first. Lane l valid only if >= l+1 grants.
//   - granted[i] is a function of slot state and rr_ptr only.
//   - fu_stall[i] = full[i] & ~granted[i] & ~squash.
//   - Accept at posedge: slot i loads input when fu_valid[i] & ~fu_stall[i].
//     Granted slot with no new input clears full; granted slot with new input
//     reloads (stays full). Ungranted full slot holds; input ignored (FU stalls).
//   - Latency: result accepted at edge k is on CDB in cycle k..k+1 at earliest
//     (exactly 1 cycle if granted immediately); worst case
//     ceil(NUM_FU/CDB_W) cycles under full contention.
//   - rr_ptr: if >=1 grant this cycle, rr_ptr <= (last granted idx + 1) mod
//     NUM_FU; else unchanged. Guarantees no FU starves.
//   - Squash: during squash cycle cdb_valid forced 0, fu_stall forced 0; at
//     edge all slots cleared and all fu inputs that cycle dropped; rr_ptr held.
//   - Squash and reset together: reset wins (identical result).
//   - Order: within a cycle lanes are in rr order; no cross-FU age ordering
//     (ROB tags resolve order).
// TESTING
//   1. Reset: assert reset mid-run with 3 slots full -> cdb_valid=00, fu_stall=0000
//      immediately, rr_ptr=0 after release.
//   2. Single result: fu_valid[2]=1 tag=5 value=0x1234 one cycle -> next cycle
//      cdb_valid=01, lane0 tag=5 value=0x1234 fu_idx=2; following cycle idle.
//   3. Contention: all 4 FUs valid at once (tags 1..4), rr_ptr=0 -> cycle1 lanes
//      {FU0,FU1}, FU2/FU3 fu_stall=1; cycle2 lanes {FU2,FU3}; rr_ptr=0 after.
//   4. Streaming: FU1 valid every cycle (tags 0..7), others idle -> one CDB result
//      per cycle, fu_stall[1] never asserted, tags in order.
//   5. Fairness: FU0,FU1,FU2 valid continuously, CDB_W=2 -> each FU granted
//      >= 2 of every 3 cycles, no FU ungranted for 2 consecutive cycles.
//   6. Squash: slots 0,3 full + fu_valid[1] with squash=1 -> cdb_valid=00 that
//      cycle, all slots empty next cycle, tag from FU1 never appears on CDB.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Completion stage: one holding slot per FU, round-robin broadcast of
// up to CDB_W results per cycle on the common data bus.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32,
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]  fu_value,
  input  logic [NUM_FU-1:0]       fu_take_branch,
  output logic [NUM_FU-1:0]       fu_stall,
  output logic [CDB_W-1:0]        cdb_valid,
  output logic [CDB_W*TAG_W-1:0]  cdb_tag,
  output logic [CDB_W*XLEN-1:0]   cdb_value,
  output logic [CDB_W-1:0]        cdb_take_branch,
  output logic [CDB_W*IDX_W-1:0]  cdb_fu_idx
);

  localparam int CNT_W = $clog2(CDB_W + 1);

  logic [NUM_FU-1:0] r_full;
  logic [TAG_W-1:0]  r_tag [NUM_FU];
  logic [XLEN-1:0]   r_value [NUM_FU];
  logic [NUM_FU-1:0] r_br;
  logic [IDX_W-1:0]  r_rr_ptr;

  logic [NUM_FU-1:0]            w_granted;
  logic [NUM_FU-1:0]            w_stall;
  logic                         w_any;
  logic [IDX_W-1:0]             w_last;
  logic [IDX_W-1:0]             w_idx;
  logic [CNT_W-1:0]             w_cnt;
  logic [CDB_W-1:0]             w_lane_vld;
  logic [CDB_W-1:0][IDX_W-1:0]  w_lane_fu;

  // Scan from rr_ptr; the first CDB_W full slots fill lanes in order.
  always_comb begin
    w_granted  = '0;
    w_any      = 1'b0;
    w_last     = '0;
    w_idx      = '0;
    w_cnt      = '0;
    w_lane_vld = '0;
    w_lane_fu  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_idx = r_rr_ptr + IDX_W'(k);
      if (r_full[w_idx] && (w_cnt < CNT_W'(CDB_W))) begin
        for (int l = 0; l < CDB_W; l++) begin
          if (w_cnt == CNT_W'(l)) begin
            w_lane_vld[l] = 1'b1;
            w_lane_fu[l]  = w_idx;
          end
        end
        w_granted[w_idx] = 1'b1;
        w_last           = w_idx;
        w_any            = 1'b1;
        w_cnt            = w_cnt + CNT_W'(1);
      end
    end
  end

  assign w_stall  = r_full & ~w_granted & {NUM_FU{~squash}};
  assign fu_stall = w_stall;

  always_comb begin
    cdb_valid       = '0;
    cdb_tag         = '0;
    cdb_value       = '0;
    cdb_take_branch = '0;
    cdb_fu_idx      = '0;
    for (int l = 0; l < CDB_W; l++) begin
      if (w_lane_vld[l] && !squash) begin
        cdb_valid[l]                 = 1'b1;
        cdb_tag[l*TAG_W +: TAG_W]    = r_tag[w_lane_fu[l]];
        cdb_value[l*XLEN +: XLEN]    = r_value[w_lane_fu[l]];
        cdb_take_branch[l]           = r_br[w_lane_fu[l]];
        cdb_fu_idx[l*IDX_W +: IDX_W] = w_lane_fu[l];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full   <= '0;
      r_br     <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_tag[i]   <= '0;
        r_value[i] <= '0;
      end
    end else if (squash) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && !w_stall[i]) begin
          r_full[i]  <= 1'b1;
          r_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
          r_value[i] <= fu_value[i*XLEN +: XLEN];
          r_br[i]    <= fu_take_branch[i];
        end else if (w_granted[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      if (w_any) r_rr_ptr <= w_last + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single, contention,
// streaming, fairness and squash scenarios.
module tb_cdb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic [3:0]  fu_valid = '0;
  logic [19:0] fu_tag = '0;
  logic [127:0] fu_value = '0;
  logic [3:0]  fu_take_branch = '0;
  logic [3:0]  fu_stall;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic [1:0]  cdb_take_branch;
  logic [3:0]  cdb_fu_idx;

  int checks = 0;
  int errors = 0;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
    .fu_take_branch(fu_take_branch), .fu_stall(fu_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_take_branch(cdb_take_branch), .cdb_fu_idx(cdb_fu_idx)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    fu_valid = '0;
    fu_tag = '0;
    fu_value = '0;
    fu_take_branch = '0;
  endtask

  task automatic set_fu(input int i, input logic [4:0] t,
                        input logic [31:0] v, input logic b);
    fu_valid[i] = 1'b1;
    fu_tag[i*5 +: 5] = t;
    fu_value[i*32 +: 32] = v;
    fu_take_branch[i] = b;
  endtask

  task automatic do_reset();
    clear_in();
    squash = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_fu(0, 5'd1, 32'h11, 1'b0);
    set_fu(1, 5'd2, 32'h22, 1'b0);
    set_fu(2, 5'd3, 32'h33, 1'b0);
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_valid !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre_valid: got %b want 11", cdb_valid);
    end
    checks++;
    if (fu_stall !== 4'b0100) begin
      errors++;
      $display("FAIL rst_pre_stall: got %b want 0100", fu_stall);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000 || cdb_tag !== '0) begin
      errors++;
      $display("FAIL rst_async: valid %b stall %b tag %h want 00 0000 0",
               cdb_valid, fu_stall, cdb_tag);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("FAIL rst_discard: got %b want 00", cdb_valid);
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) set_fu(i, 5'(i + 1), 32'h100 + i, 1'b0);
    @(negedge clock);
    checks++;
    if (cdb_valid !== 2'b11 || cdb_fu_idx !== 4'b0100 ||
        cdb_tag[4:0] !== 5'd1 || cdb_tag[9:5] !== 5'd2) begin
      errors++;
      $display("FAIL cont_c1: valid %b idx %b tag %h want 11 0100 tags 1,2",
               cdb_valid, cdb_fu_idx, cdb_tag);
    end
    checks++;
    if (fu_stall !== 4'b1100) begin
      errors++;
      $display("FAIL cont_stall: got %b want 1100", fu_stall);
    end
    fu_valid = 4'b1100;
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_fu_idx !== 4'b1110 ||
        cdb_tag[4:0] !== 5'd3 || cdb_tag[9:5] !== 5'd4 ||
        cdb_value[63:32] !== 32'h103 || fu_stall !== 4'b0000) begin
      errors++;
      $display("FAIL cont_c2: valid %b idx %b tag %h v1 %h stall %b",
               cdb_valid, cdb_fu_idx, cdb_tag, cdb_value[63:32], fu_stall);
    end
    @(negedge clock);
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("FAIL cont_idle: got %b want 00", cdb_valid);
    end
    set_fu(3, 5'd9, 32'h9, 1'b0);
    set_fu(0, 5'd8, 32'h8, 1'b0);
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_fu_idx !== 4'b1100 || cdb_tag[4:0] !== 5'd8 ||
        cdb_tag[9:5] !== 5'd9) begin
      errors++;
      $display("FAIL cont_rr0: idx %b tag %h want 1100 tags 8,9",
               cdb_fu_idx, cdb_tag);
    end
    @(negedge clock);
  endtask

  task automatic test_single();
    set_fu(2, 5'd5, 32'h1234, 1'b1);
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_tag !== 10'd5 ||
        cdb_value !== 64'h1234 || cdb_fu_idx !== 4'b0010 ||
        cdb_take_branch !== 2'b01) begin
      errors++;
      $display("FAIL single: valid %b tag %h val %h idx %b br %b",
               cdb_valid, cdb_tag, cdb_value, cdb_fu_idx, cdb_take_branch);
    end
    @(negedge clock);
    checks++;
    if (cdb_valid !== 2'b00 || cdb_value !== '0) begin
      errors++;
      $display("FAIL single_idle: valid %b val %h want 00 0",
               cdb_valid, cdb_value);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++;
        if (cdb_valid !== 2'b01 || cdb_tag[4:0] !== 5'(i - 1) ||
            cdb_fu_idx[1:0] !== 2'd1 || fu_stall !== 4'b0000) begin
          errors++;
          $display("FAIL stream_%0d: valid %b tag %0d idx %0d stall %b",
                   i, cdb_valid, cdb_tag[4:0], cdb_fu_idx[1:0], fu_stall);
        end
      end
      clear_in();
      if (i < 8) set_fu(1, 5'(i), 32'h50 + i, 1'b0);
      @(negedge clock);
    end
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("FAIL stream_end: got %b want 00", cdb_valid);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_stall [6] = '{4'b0100, 4'b0010, 4'b0001,
                                  4'b0100, 4'b0010, 4'b0001};
    logic [1:0] exp_l0 [6] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [1:0] exp_l1 [6] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) set_fu(i, 5'(10 + i), 32'h0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      checks++;
      if (cdb_valid !== 2'b11 || fu_stall !== exp_stall[n] ||
          cdb_fu_idx[1:0] !== exp_l0[n] || cdb_fu_idx[3:2] !== exp_l1[n] ||
          cdb_tag[4:0] !== 5'(10 + exp_l0[n])) begin
        errors++;
        $display("FAIL fair_%0d: valid %b stall %b idx %b tag0 %0d want stall %b lanes %0d,%0d",
                 n, cdb_valid, fu_stall, cdb_fu_idx, cdb_tag[4:0],
                 exp_stall[n], exp_l0[n], exp_l1[n]);
      end
    end
    clear_in();
  endtask

  task automatic test_squash();
    do_reset();
    set_fu(1, 5'd7, 32'h7, 1'b0);
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_fu_idx[1:0] !== 2'd1) begin
      errors++;
      $display("FAIL sq_pre1: valid %b idx %b", cdb_valid, cdb_fu_idx);
    end
    set_fu(0, 5'h11, 32'h11, 1'b0);
    set_fu(2, 5'h12, 32'h12, 1'b0);
    set_fu(3, 5'h13, 32'h13, 1'b0);
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_fu_idx !== 4'b1110 ||
        fu_stall !== 4'b0001) begin
      errors++;
      $display("FAIL sq_pre2: valid %b idx %b stall %b want 11 1110 0001",
               cdb_valid, cdb_fu_idx, fu_stall);
    end
    squash = 1'b1;
    set_fu(1, 5'h1B, 32'hBB, 1'b1);
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
      errors++;
      $display("FAIL sq_force: valid %b stall %b want 00 0000",
               cdb_valid, fu_stall);
    end
    @(negedge clock);
    squash = 1'b0;
    clear_in();
    checks++;
    if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
      errors++;
      $display("FAIL sq_clear: valid %b stall %b want 00 0000",
               cdb_valid, fu_stall);
    end
    @(negedge clock);
    checks++;
    if (cdb_valid !== 2'b00 || cdb_tag !== '0) begin
      errors++;
      $display("FAIL sq_drop: valid %b tag %h want 00 0", cdb_valid, cdb_tag);
    end
    set_fu(1, 5'h0A, 32'hA, 1'b0);
    set_fu(2, 5'h0C, 32'hC, 1'b0);
    @(negedge clock);
    clear_in();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_fu_idx !== 4'b0110 ||
        cdb_tag[4:0] !== 5'h0C || cdb_tag[9:5] !== 5'h0A) begin
      errors++;
      $display("FAIL sq_rr_held: valid %b idx %b tag %h want 11 0110 0C,0A",
               cdb_valid, cdb_fu_idx, cdb_tag);
    end
    @(negedge clock);
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("FAIL sq_end: got %b want 00", cdb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_streaming();
    test_fairness();
    test_squash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
